// File: rtl/router_pkg.sv
// Shared router types: flit format, flit type codes, port indices and XY routing helper.
package router_pkg;

  localparam int unsigned NUM_OF_PORTS = 5;
  localparam int unsigned COORD_W      = 4;
  localparam int unsigned PORT_W       = 3;
  localparam int unsigned PAYLOAD_W    = 32;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  // Bits [33:32] type, [31:0] payload; head payload carries dest_x in [7:4], dest_y in [3:0].
  typedef struct packed {
    flit_type_e             ftype;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  localparam logic [PORT_W-1:0] LOCAL = 3'd0;
  localparam logic [PORT_W-1:0] NORTH = 3'd1;
  localparam logic [PORT_W-1:0] EAST  = 3'd2;
  localparam logic [PORT_W-1:0] SOUTH = 3'd3;
  localparam logic [PORT_W-1:0] WEST  = 3'd4;

  function automatic logic is_head(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

  // Dimension-ordered routing: resolve X first, then Y.
  function automatic logic [PORT_W-1:0] xy_route(input logic [COORD_W-1:0] dx,
                                                 input logic [COORD_W-1:0] dy,
                                                 input logic [COORD_W-1:0] mx,
                                                 input logic [COORD_W-1:0] my);
    if (dx > mx)      return EAST;
    else if (dx < mx) return WEST;
    else if (dy > my) return NORTH;
    else if (dy < my) return SOUTH;
    else              return LOCAL;
  endfunction

endpackage

// File: rtl/input_fifo.sv
// Synchronous flit FIFO with registered occupancy count and full/empty flags.
module input_fifo
  import router_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  flit_t                  din,
  output flit_t                  front,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign front   = mem[rd_ptr];

  // Storage array; contents are only observed through a valid read pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_unit.sv
// Router input port: buffers upstream flits, XY-routes each packet and forwards it to the switch.
module input_unit
  import router_pkg::*;
#(
  parameter logic [COORD_W-1:0] MY_X      = 4'd0,
  parameter logic [COORD_W-1:0] MY_Y      = 4'd0,
  parameter int unsigned        BUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_upstream_req,
  input  flit_t                      i_flit,
  output logic                       o_upstream_ack,
  input  logic [NUM_OF_PORTS-1:0]    i_switch_ack,
  output logic [NUM_OF_PORTS-1:0]    o_switch_req,
  output flit_t                      o_flit,
  output logic                       o_flit_valid,
  output logic [$clog2(BUF_DEPTH):0] o_fifo_count,
  output logic                       o_err
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [NUM_OF_PORTS-1:0] PORT_ONE = NUM_OF_PORTS'(1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state;
  state_e            state_nxt;
  logic [PORT_W-1:0] route;
  logic [PORT_W-1:0] route_nxt;
  logic [CW-1:0]     count_nxt;
  flit_t             front;
  logic              full;
  logic              empty;
  logic              push;
  logic              grant;
  logic              discard;
  logic              pop;

  // One accept per ack pulse: a request still held during the ack is not pushed again.
  assign push    = i_upstream_req && !full && !o_upstream_ack;
  assign grant   = (state == ACTIVE) && !empty && i_switch_ack[route];
  assign discard = (state == IDLE) && !empty && !is_head(front.ftype);
  assign pop     = grant || discard;

  input_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (i_flit),
    .front   (front),
    .count   (o_fifo_count),
    .full    (full),
    .empty   (empty)
  );

  // Next route/state; also the look-ahead occupancy used to register o_switch_req.
  always_comb begin
    state_nxt = state;
    route_nxt = route;
    count_nxt = o_fifo_count + CW'(push) - CW'(pop);
    if ((state == IDLE) && !empty && is_head(front.ftype)) begin
      route_nxt = xy_route(front.payload[7:4], front.payload[3:0], MY_X, MY_Y);
      state_nxt = ACTIVE;
    end
    if (grant && is_tail(front.ftype)) begin
      state_nxt = IDLE;
    end
  end

  // Route FSM and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      route          <= LOCAL;
      o_upstream_ack <= 1'b0;
      o_switch_req   <= '0;
      o_flit         <= '0;
      o_flit_valid   <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      state          <= state_nxt;
      route          <= route_nxt;
      o_upstream_ack <= push;
      o_switch_req   <= ((state_nxt == ACTIVE) && (count_nxt != '0)) ? (PORT_ONE << route_nxt) : '0;
      o_flit_valid   <= grant;
      o_err          <= discard;
      if (grant) o_flit <= front;
    end
  end

endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit at MY_X=1, MY_Y=1, BUF_DEPTH=4.
module tb_input_unit;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_upstream_req;
  flit_t       i_flit;
  logic        o_upstream_ack;
  logic [4:0]  i_switch_ack;
  logic [4:0]  o_switch_req;
  flit_t       o_flit;
  logic        o_flit_valid;
  logic [2:0]  o_fifo_count;
  logic        o_err;

  int tests = 0;
  int fails = 0;

  input_unit #(.MY_X(4'd1), .MY_Y(4'd1), .BUF_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_upstream_req (i_upstream_req),
    .i_flit         (i_flit),
    .o_upstream_ack (o_upstream_ack),
    .i_switch_ack   (i_switch_ack),
    .o_switch_req   (o_switch_req),
    .o_flit         (o_flit),
    .o_flit_valid   (o_flit_valid),
    .o_fifo_count   (o_fifo_count),
    .o_err          (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    flit_t      flit;
    logic [4:0] ack;
    logic       e_uack;
    logic [4:0] e_sw;
    logic       e_valid;
    flit_t      e_flit;
    logic [2:0] e_cnt;
    logic       e_err;
  } vec_t;

  localparam int unsigned NV = 14;
  vec_t vecs [NV];

  function automatic flit_t mk(input flit_type_e t, input logic [31:0] p);
    flit_t f;
    f.ftype   = t;
    f.payload = p;
    return f;
  endfunction

  function automatic vec_t mkv(input logic req, input flit_t flit, input logic [4:0] ack,
                               input logic e_uack, input logic [4:0] e_sw, input logic e_valid,
                               input flit_t e_flit, input logic [2:0] e_cnt, input logic e_err);
    vec_t v;
    v.req = req; v.flit = flit; v.ack = ack;
    v.e_uack = e_uack; v.e_sw = e_sw; v.e_valid = e_valid;
    v.e_flit = e_flit; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic uack, input logic [4:0] sw,
                            input logic valid, input flit_t fl, input logic [2:0] cnt,
                            input logic err);
    check({tag, " uack"},  64'(o_upstream_ack), 64'(uack));
    check({tag, " sw"},    64'(o_switch_req),   64'(sw));
    check({tag, " valid"}, 64'(o_flit_valid),   64'(valid));
    check({tag, " flit"},  64'(o_flit),         64'(fl));
    check({tag, " count"}, 64'(o_fifo_count),   64'(cnt));
    check({tag, " err"},   64'(o_err),          64'(err));
  endtask

  // Hold a request until acked (bounded), then drop it; returns at the negedge showing the ack.
  task automatic send_flit(input string name, input flit_t f);
    logic got = 1'b0;
    i_upstream_req = 1'b1;
    i_flit         = f;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_upstream_ack) begin
        got = 1'b1;
        break;
      end
    end
    i_upstream_req = 1'b0;
    check({name, " acked"}, 64'(got), 64'd1);
  endtask

  flit_t ht, hd, bd, tl, st, b1, b2, b3, b5, z;
  int    stray;

  initial begin
    ht = mk(FLIT_HEAD_TAIL, 32'h0000_0011);
    hd = mk(FLIT_HEAD,      32'h0000_0030);
    bd = mk(FLIT_BODY,      32'h0000_B0D1);
    tl = mk(FLIT_TAIL,      32'h0000_7A11);
    st = mk(FLIT_BODY,      32'h0000_0055);
    b1 = mk(FLIT_BODY,      32'h0000_0B01);
    b2 = mk(FLIT_BODY,      32'h0000_0B02);
    b3 = mk(FLIT_BODY,      32'h0000_0B03);
    b5 = mk(FLIT_BODY,      32'h0000_0B05);
    z  = '0;

    // HEAD_TAIL to local, then HEAD(3,0)/BODY/TAIL east with a foreign-grant stall, then stray BODY.
    vecs[0]  = mkv(1'b1, ht, 5'b11111, 1'b1, 5'b00000, 1'b0, z,  3'd1, 1'b0);
    vecs[1]  = mkv(1'b0, ht, 5'b11111, 1'b0, 5'b00001, 1'b0, z,  3'd1, 1'b0);
    vecs[2]  = mkv(1'b0, ht, 5'b11111, 1'b0, 5'b00000, 1'b1, ht, 3'd0, 1'b0);
    vecs[3]  = mkv(1'b0, ht, 5'b11111, 1'b0, 5'b00000, 1'b0, ht, 3'd0, 1'b0);
    vecs[4]  = mkv(1'b1, hd, 5'b00100, 1'b1, 5'b00000, 1'b0, ht, 3'd1, 1'b0);
    vecs[5]  = mkv(1'b1, bd, 5'b00100, 1'b0, 5'b00100, 1'b0, ht, 3'd1, 1'b0);
    vecs[6]  = mkv(1'b1, bd, 5'b11011, 1'b1, 5'b00100, 1'b0, ht, 3'd2, 1'b0);
    vecs[7]  = mkv(1'b0, bd, 5'b00100, 1'b0, 5'b00100, 1'b1, hd, 3'd1, 1'b0);
    vecs[8]  = mkv(1'b1, tl, 5'b00100, 1'b1, 5'b00100, 1'b1, bd, 3'd1, 1'b0);
    vecs[9]  = mkv(1'b0, tl, 5'b00100, 1'b0, 5'b00000, 1'b1, tl, 3'd0, 1'b0);
    vecs[10] = mkv(1'b0, tl, 5'b00100, 1'b0, 5'b00000, 1'b0, tl, 3'd0, 1'b0);
    vecs[11] = mkv(1'b1, st, 5'b00000, 1'b1, 5'b00000, 1'b0, tl, 3'd1, 1'b0);
    vecs[12] = mkv(1'b0, st, 5'b00000, 1'b0, 5'b00000, 1'b0, tl, 3'd0, 1'b1);
    vecs[13] = mkv(1'b0, st, 5'b00000, 1'b0, 5'b00000, 1'b0, tl, 3'd0, 1'b0);

    reset_n        = 1'b0;
    i_upstream_req = 1'b0;
    i_flit         = '0;
    i_switch_ack   = '0;
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 5'b0, 1'b0, z, 3'd0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      i_upstream_req = vecs[i].req;
      i_flit         = vecs[i].flit;
      i_switch_ack   = vecs[i].ack;
      @(negedge clk);
      check_outs($sformatf("v%0d", i), vecs[i].e_uack, vecs[i].e_sw, vecs[i].e_valid,
                 vecs[i].e_flit, vecs[i].e_cnt, vecs[i].e_err);
    end

    // Asynchronous reset with two flits of a packet buffered.
    i_switch_ack = '0;
    send_flit("rst hd", hd);
    send_flit("rst b1", b1);
    check("rst pre count", 64'(o_fifo_count), 64'd2);
    check("rst pre sw",    64'(o_switch_req), 64'h04);
    #2 reset_n = 1'b0;
    #1 check_outs("async rst", 1'b0, 5'b0, 1'b0, z, 3'd0, 1'b0);
    i_upstream_req = 1'b1;
    i_flit         = hd;
    @(posedge clk);
    #1 check("no accept in reset", 64'(o_upstream_ack), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("first accept", 64'(o_upstream_ack), 64'd1);
    i_upstream_req = 1'b0;

    // Fill the FIFO with grants off; the fifth request waits for a pop.
    send_flit("fill b1", b1);
    send_flit("fill b2", b2);
    send_flit("fill b3", b3);
    check("full count", 64'(o_fifo_count), 64'd4);
    i_upstream_req = 1'b1;
    i_flit         = b5;
    stray          = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_upstream_ack) stray++;
    end
    check("full no ack", 64'(stray), 64'd0);
    check("full hold count", 64'(o_fifo_count), 64'd4);
    i_switch_ack = 5'b00100;
    @(negedge clk);
    i_switch_ack = '0;
    check("full pop count", 64'(o_fifo_count), 64'd3);
    check("full pop flit",  64'(o_flit), 64'(hd));
    check("full pop valid", 64'(o_flit_valid), 64'd1);
    check("full pop uack",  64'(o_upstream_ack), 64'd0);
    @(negedge clk);
    check("5th acked", 64'(o_upstream_ack), 64'd1);
    check("5th count", 64'(o_fifo_count), 64'd4);
    i_upstream_req = 1'b0;

    // Simultaneous push and pop at count 2, order preserved to the tail.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    send_flit("pp hd", hd);
    send_flit("pp b1", b1);
    @(negedge clk);
    i_upstream_req = 1'b1;
    i_flit         = b2;
    i_switch_ack   = 5'b00100;
    @(negedge clk);
    i_upstream_req = 1'b0;
    check_outs("pp0", 1'b1, 5'b00100, 1'b1, hd, 3'd2, 1'b0);
    @(negedge clk);
    check_outs("pp1", 1'b0, 5'b00100, 1'b1, b1, 3'd1, 1'b0);
    i_upstream_req = 1'b1;
    i_flit         = tl;
    @(negedge clk);
    i_upstream_req = 1'b0;
    check_outs("pp2", 1'b1, 5'b00100, 1'b1, b2, 3'd1, 1'b0);
    @(negedge clk);
    check_outs("pp3", 1'b0, 5'b00000, 1'b1, tl, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
